// File: rtl/mul_final_add.sv
// Final carry-propagate stage of the Wallace-tree multiplier: resolves the last
// CSA sum/carry pair into the product through a low-slice / high-slice split adder.
module mul_final_add #(
  parameter int DATA_WIDTH = 64,
  parameter int LOW_WIDTH  = 64
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic [1:0]                MulHoldFlagFromEx,
  input  logic [2*DATA_WIDTH-1:0]   SumPP_CSA50,
  input  logic [2*DATA_WIDTH-1:0]   CarryPP_CSA50,
  output logic [2*DATA_WIDTH-1:0]   Sum,
  output logic                      MulHoldEndToEx
);

  localparam int PROD_WIDTH = 2 * DATA_WIDTH;
  localparam int HIGH_WIDTH = PROD_WIDTH - LOW_WIDTH;

  logic                  valid_s;
  logic                  flush_s;
  logic [LOW_WIDTH:0]    lo_add_s;
  logic [HIGH_WIDTH-1:0] hi_res_s;

  logic                  vld_a_r;
  logic                  cy_a_r;
  logic [LOW_WIDTH-1:0]  lo_res_r;
  logic [HIGH_WIDTH-1:0] hi_s_r;
  logic [HIGH_WIDTH-1:0] hi_c_r;

  // Decode the EX hold flags; flush overrides valid.
  always_comb begin
    flush_s = MulHoldFlagFromEx[1];
    if (MulHoldFlagFromEx[1]) begin
      valid_s = 1'b0;
    end else begin
      valid_s = MulHoldFlagFromEx[0];
    end
  end

  // Low-slice add with carry out, and the high-slice completion using that carry.
  always_comb begin
    lo_add_s = {1'b0, SumPP_CSA50[LOW_WIDTH-1:0]} + {1'b0, CarryPP_CSA50[LOW_WIDTH-1:0]};
    hi_res_s = hi_s_r + hi_c_r + {{(HIGH_WIDTH-1){1'b0}}, cy_a_r};
  end

  // Stage A: register low result, its carry, the raw high slices and the valid bit.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      vld_a_r  <= 1'b0;
      cy_a_r   <= 1'b0;
      lo_res_r <= {LOW_WIDTH{1'b0}};
      hi_s_r   <= {HIGH_WIDTH{1'b0}};
      hi_c_r   <= {HIGH_WIDTH{1'b0}};
    end else begin
      vld_a_r  <= valid_s;
      cy_a_r   <= lo_add_s[LOW_WIDTH];
      lo_res_r <= lo_add_s[LOW_WIDTH-1:0];
      hi_s_r   <= SumPP_CSA50[PROD_WIDTH-1:LOW_WIDTH];
      hi_c_r   <= CarryPP_CSA50[PROD_WIDTH-1:LOW_WIDTH];
    end
  end

  // Stage B: a flush at this edge also cancels the op sitting in stage A.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      Sum            <= {PROD_WIDTH{1'b0}};
      MulHoldEndToEx <= 1'b0;
    end else begin
      MulHoldEndToEx <= vld_a_r & ~flush_s;
      if (vld_a_r && !flush_s) begin
        Sum <= {hi_res_s, lo_res_r};
      end else begin
        Sum <= Sum;
      end
    end
  end

endmodule

// File: tb/tb_mul_final_add.sv
// Self-checking bench for mul_final_add: whole-product reference model compared
// every cycle, plus directed vectors with literal expectations.
module tb_mul_final_add;

  logic         Clk;
  logic         Rst;
  logic [1:0]   flag;
  logic [127:0] sa;
  logic [127:0] ca;
  logic [127:0] Sum;
  logic         MulHoldEndToEx;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 1'b0;

  // Reference model: one pending op (full 128-bit sum) and the visible outputs.
  logic         m_va  = 1'b0;
  logic [127:0] m_pa  = 128'h0;
  logic [127:0] m_sum = 128'h0;
  logic         m_end = 1'b0;

  mul_final_add #(.DATA_WIDTH(64), .LOW_WIDTH(64)) dut (
    .Clk               (Clk),
    .Rst               (Rst),
    .MulHoldFlagFromEx (flag),
    .SumPP_CSA50       (sa),
    .CarryPP_CSA50     (ca),
    .Sum               (Sum),
    .MulHoldEndToEx    (MulHoldEndToEx)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  always @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      m_va  <= 1'b0;
      m_pa  <= 128'h0;
      m_sum <= 128'h0;
      m_end <= 1'b0;
    end else begin
      m_end <= m_va && !flag[1];
      if (m_va && !flag[1]) m_sum <= m_pa;
      m_va  <= flag[0] && !flag[1];
      m_pa  <= sa + ca;
    end
  end

  always @(negedge Clk) begin
    if (cmp_en) begin
      checks++;
      if (Sum !== m_sum || MulHoldEndToEx !== m_end) begin
        failures++;
        $display("FAIL model_cmp t=%0t sum act=%h exp=%h end act=%b exp=%b",
                 $time, Sum, m_sum, MulHoldEndToEx, m_end);
      end
    end
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic op(input logic [127:0] a, input logic [127:0] b, input logic [1:0] f);
    sa   = a;
    ca   = b;
    flag = f;
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    op(128'h0, 128'h0, 2'b00);
  endtask

  initial begin
    logic [127:0] neg1;
    neg1 = {128{1'b1}};
    Rst  = 1'b0;
    flag = 2'b00;
    sa   = 128'h0;
    ca   = 128'h0;
    repeat (2) @(posedge Clk);
    #1;
    chk("reset_sum", Sum, 128'h0);
    chk("reset_end", {127'h0, MulHoldEndToEx}, 128'h0);
    cmp_en = 1'b1;
    Rst    = 1'b1;
    repeat (10) idle();
    chk("idle_sum", Sum, 128'h0);
    chk("idle_end", {127'h0, MulHoldEndToEx}, 128'h0);

    // Low-half carry ripples into the high half.
    op(128'h0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFF, 128'h1, 2'b01);
    chk("lat1_no_pulse", {127'h0, MulHoldEndToEx}, 128'h0);
    idle();
    chk("lowcarry_sum", Sum, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    chk("lowcarry_end", {127'h0, MulHoldEndToEx}, 128'h1);
    idle();
    chk("lowcarry_single", {127'h0, MulHoldEndToEx}, 128'h0);
    chk("lowcarry_hold", Sum, 128'h0000_0000_0000_0001_0000_0000_0000_0000);

    // Carry out of bit 127 dropped.
    op(128'h8000_0000_0000_0000_0000_0000_0000_0001,
       128'h8000_0000_0000_0000_0000_0000_0000_0001, 2'b01);
    idle();
    chk("wrap_sum", Sum, 128'h2);
    chk("wrap_end", {127'h0, MulHoldEndToEx}, 128'h1);

    // Streaming: sums 1..4 via (-1)+(k+1); flush arrives with op 4 and kills op 3 in stage B.
    op(neg1, 128'd2, 2'b01);
    op(neg1, 128'd3, 2'b01);
    chk("stream_op1_sum", Sum, 128'd1);
    chk("stream_op1_end", {127'h0, MulHoldEndToEx}, 128'h1);
    op(neg1, 128'd4, 2'b01);
    chk("stream_op2_sum", Sum, 128'd2);
    chk("stream_op2_end", {127'h0, MulHoldEndToEx}, 128'h1);
    op(neg1, 128'd5, 2'b11);
    chk("stream_op3_cancel", {127'h0, MulHoldEndToEx}, 128'h0);
    idle();
    chk("stream_op4_drop", {127'h0, MulHoldEndToEx}, 128'h0);
    repeat (3) idle();
    chk("stream_final_sum", Sum, 128'd2);

    // Variant: flush as op 2 sits in stage A -> only op 1 completes.
    op(128'd5, 128'd6, 2'b01);
    op(128'd7, 128'd8, 2'b01);
    chk("var_op1_sum", Sum, 128'd11);
    op(128'd9, 128'd9, 2'b11);
    chk("var_op2_cancel", {127'h0, MulHoldEndToEx}, 128'h0);
    chk("var_hold", Sum, 128'd11);
    repeat (3) idle();
    chk("var_final_sum", Sum, 128'd11);

    // Async reset between E0 and E1.
    op(128'h1234, 128'h1111, 2'b01);
    flag = 2'b00;
    #2;
    Rst = 1'b0;
    #1;
    chk("async_sum", Sum, 128'h0);
    chk("async_end", {127'h0, MulHoldEndToEx}, 128'h0);
    @(negedge Clk);
    #2;
    Rst = 1'b1;
    repeat (3) begin
      idle();
      chk("async_no_pulse", {127'h0, MulHoldEndToEx}, 128'h0);
    end
    chk("async_sum_held0", Sum, 128'h0);

    // Random regression, checked by the per-cycle model compare.
    for (int i = 0; i < 10000; i++) begin
      logic [127:0] ra;
      logic [127:0] rb;
      logic [1:0]   rf;
      ra = {$urandom, $urandom, $urandom, $urandom};
      rb = {$urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 9) == 0) rb = ~ra + 128'd1;
      rf[0] = $urandom_range(0, 1) == 1;
      rf[1] = $urandom_range(0, 99) < 5;
      op(ra, rb, rf);
    end
    repeat (3) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
